// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand loader.
// Optional build macro used by this slice: MATLOAD_OUTPUT_MASK_EN.
package matrix_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int NUM_OPERANDS = 8;
  localparam int IDX_W        = 3;
  localparam int CNT_W        = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OPERANDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_OPERANDS);

  localparam logic [IDX_W-1:0] SLOT_A11 = 3'd0;
  localparam logic [IDX_W-1:0] SLOT_A12 = 3'd1;
  localparam logic [IDX_W-1:0] SLOT_A21 = 3'd2;
  localparam logic [IDX_W-1:0] SLOT_A22 = 3'd3;
  localparam logic [IDX_W-1:0] SLOT_B11 = 3'd4;
  localparam logic [IDX_W-1:0] SLOT_B12 = 3'd5;
  localparam logic [IDX_W-1:0] SLOT_B21 = 3'd6;
  localparam logic [IDX_W-1:0] SLOT_B22 = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } matload_state_t;

endpackage

// File: rtl/matrix_operand_regs.sv
// Eight-entry operand register file with parallel read-out.
// With MATLOAD_OUTPUT_MASK_EN the outputs read 0 unless show_i is set.
module matrix_operand_regs
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 we_i,
  input  logic [IDX_W-1:0]                     widx_i,
  input  logic [DATA_W-1:0]                    wdata_i,
  input  logic                                 show_i,
  output logic [NUM_OPERANDS-1:0][DATA_W-1:0]  q_o
);

  logic [NUM_OPERANDS-1:0][DATA_W-1:0] rf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '0;
    end else if (we_i) begin
      rf_q[widx_i] <= wdata_i;
    end
  end

`ifdef MATLOAD_OUTPUT_MASK_EN
  // Keep downstream from seeing a partially filled set.
  assign q_o = show_i ? rf_q : '0;
`else
  logic unused_show;
  assign unused_show = show_i;
  assign q_o = rf_q;
`endif

endmodule

// File: rtl/matrix_operand_loader.sv
// Fetches 2x2 by 2x2 operands from memory and holds them for the multiplier.
// Optional build macro: MATLOAD_OUTPUT_MASK_EN (mask operands until valid).
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] b11,
  output logic [DATA_W-1:0] b12,
  output logic [DATA_W-1:0] b21,
  output logic [DATA_W-1:0] b22,
  output logic              mat_valid,
  input  logic              mat_ack,
  output logic              busy,
  output logic              err
);

  matload_state_t state_q, state_d;

  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  returned_q, returned_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_q, err_d;
  logic              mat_valid_q;
  logic              hs;
  logic              rsp_ok;

  logic [NUM_OPERANDS-1:0][DATA_W-1:0] ops;

  assign req_valid = (state_q == FETCH) && (issued_q < CNT_FULL);
  assign req_addr  = req_valid ? base_q + ADDR_W'(issued_q) : '0;
  assign busy      = (state_q != IDLE);
  assign hs        = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    base_d     = base_q;
    err_d      = err_q;
    rsp_ok     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          base_d     = base_addr;
          issued_d   = '0;
          returned_d = '0;
          err_d      = 1'b0;
        end
      end
      FETCH: begin
        // Response is judged against issued before this cycle's request.
        rsp_ok = rsp_valid && (returned_q < issued_q);
        if (hs) begin
          issued_d = issued_q + CNT_W'(1);
        end
        if (rsp_ok) begin
          returned_d = returned_q + CNT_W'(1);
          if (returned_q == CNT_LAST) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (mat_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rsp_valid && !rsp_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      returned_q  <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
      mat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      base_q      <= base_d;
      err_q       <= err_d;
      mat_valid_q <= (state_d == HOLD);
    end
  end

  matrix_operand_regs #(
    .DATA_W (DATA_W)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rsp_ok),
    .widx_i  (returned_q[IDX_W-1:0]),
    .wdata_i (rsp_data),
    .show_i  (mat_valid_q),
    .q_o     (ops)
  );

  assign a11       = ops[SLOT_A11];
  assign a12       = ops[SLOT_A12];
  assign a21       = ops[SLOT_A21];
  assign a22       = ops[SLOT_A22];
  assign b11       = ops[SLOT_B11];
  assign b12       = ops[SLOT_B12];
  assign b21       = ops[SLOT_B21];
  assign b22       = ops[SLOT_B22];
  assign mat_valid = mat_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: vector table, random loads,
// and hand-written reset/misuse sequences against a behavioural memory model.
`timescale 1ns/1ps
module tb_matrix_operand_loader;

`ifdef MATLOAD_OUTPUT_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic        mat_valid;
  logic        mat_ack = 1'b0;
  logic        busy;
  logic        err;

  logic        mem_v;
  logic [15:0] mem_d;
  logic        stray_v = 1'b0;
  logic [15:0] opv [8];

  assign rsp_valid = mem_v | stray_v;
  assign rsp_data  = mem_v ? mem_d : 16'hDEAD;

  always_comb begin
    opv[0] = a11; opv[1] = a12; opv[2] = a21; opv[3] = a22;
    opv[4] = b11; opv[5] = b12; opv[6] = b21; opv[7] = b22;
  end

  matrix_operand_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .a11       (a11),
    .a12       (a12),
    .a21       (a21),
    .a22       (a22),
    .b11       (b11),
    .b12       (b12),
    .b21       (b21),
    .b22       (b22),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order responses a fixed latency after each handshake.
  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;

  logic [15:0] mem [0:65535];
  rsp_t        pq [$];
  logic [15:0] alog [$];
  int          hs_cnt = 0;
  int          lat = 1;
  int          mode = 0;
  int          t0 = 0;

  initial begin
    rsp_t r;
    mem_v = 1'b0;
    mem_d = '0;
    req_ready = 1'b1;
    forever begin
      @(negedge clk);
      req_ready = (mode == 0) ? 1'b1 : (((cyc - t0) & 1) == 1);
      if (req_valid && req_ready) begin
        r.due = cyc + lat;
        r.d   = mem[req_addr];
        pq.push_back(r);
        alog.push_back(req_addr);
        hs_cnt++;
      end
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        mem_v = 1'b1;
        mem_d = pq[0].d;
        void'(pq.pop_front());
      end else begin
        mem_v = 1'b0;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [15:0] last_exp [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Reference: cycle of mat_valid relative to start, from handshake times.
  function automatic int ref_latency(input int l, input int m);
    int hs_t [$];
    int c = 1;
    while (hs_t.size() < 8) begin
      if (m == 0 || (c % 2) == 1) hs_t.push_back(c);
      c++;
    end
    return hs_t[7] + l + 1;
  endfunction

  task automatic run_load(input logic [15:0] base, input int l, input int m,
                          input int exp_lat, input bit seqd, input bit misuse,
                          input string tag);
    logic [15:0] exp [8];
    logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      a = base + 16'(i);
      mem[a] = seqd ? 16'(i + 1) : 16'($urandom);
      exp[i] = mem[a];
    end
    lat = l;
    mode = m;
    alog.delete();
    hs_cnt = 0;
    tick;
    start = 1'b1;
    base_addr = base;
    t0 = cyc;
    tick;
    start = 1'b0;
    check({tag, " err cleared"}, {31'd0, err}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    while (!mat_valid && (cyc - t0) < 400) begin
      start = misuse && (cyc == t0 + 3);
      base_addr = base ^ 16'h5555;
      if (l == 1 && m == 0 && cyc == t0 + 9) begin
        check({tag, " peek a11"}, {16'd0, a11}, {16'd0, MASK ? 16'd0 : exp[0]});
        check({tag, " peek b22"}, {16'd0, b22},
              {16'd0, MASK ? 16'd0 : last_exp[7]});
      end
      tick;
    end
    start = 1'b0;
    check({tag, " mat_valid"}, {31'd0, mat_valid}, 32'd1);
    check({tag, " latency"}, cyc - t0, exp_lat);
    check({tag, " handshakes"}, hs_cnt, 8);
    for (int i = 0; i < 8 && i < alog.size(); i++)
      check({tag, " addr"}, {16'd0, alog[i]}, {16'd0, base + 16'(i)});
    for (int i = 0; i < 8; i++)
      check({tag, " operand"}, {16'd0, opv[i]}, {16'd0, exp[i]});
    check({tag, " err"}, {31'd0, err}, 32'd0);
    tick;
    check({tag, " hold stable"}, {15'd0, mat_valid, b22}, {15'd0, 1'b1, exp[7]});
    mat_ack = 1'b1;
    start = misuse;
    tick;
    mat_ack = 1'b0;
    start = 1'b0;
    check({tag, " valid drop"}, {31'd0, mat_valid}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    check({tag, " regs kept"}, {16'd0, a11}, {16'd0, MASK ? 16'd0 : exp[0]});
    tick;
    check({tag, " no restart"}, {30'd0, busy, req_valid}, 32'd0);
    for (int i = 0; i < 8; i++) last_exp[i] = exp[i];
  endtask

  typedef struct {
    logic [15:0] base;
    int          lat;
    int          mode;
    int          exp_lat;
    bit          seqd;
    bit          misuse;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int l, m;
    tbl[0] = '{16'h0100, 1, 0, 10, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFC, 2, 0, 11, 1'b0, 1'b0};
    tbl[2] = '{16'h2000, 3, 1, 19, 1'b0, 1'b0};
    tbl[3] = '{16'h0400, 1, 0, 10, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) last_exp[i] = '0;

    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset req", {15'd0, req_valid, req_addr}, 32'd0);
    check("reset valid/err", {30'd0, mat_valid, err}, 32'd0);
    check("reset b22", {16'd0, b22}, 32'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;

    for (int v = 0; v < 4; v++)
      run_load(tbl[v].base, tbl[v].lat, tbl[v].mode, tbl[v].exp_lat,
               tbl[v].seqd, tbl[v].misuse, $sformatf("vec%0d", v));

    // Stray response while idle.
    stray_v = 1'b1;
    tick;
    stray_v = 1'b0;
    check("stray err", {31'd0, err}, 32'd1);
    check("stray a11", {16'd0, a11}, {16'd0, MASK ? 16'd0 : last_exp[0]});
    check("stray b22", {16'd0, b22}, {16'd0, MASK ? 16'd0 : last_exp[7]});
    tick;
    check("stray err sticky", {31'd0, err}, 32'd1);

    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, 4);
      m = $urandom_range(0, 1);
      run_load(16'($urandom), l, m, ref_latency(l, m), 1'b0, 1'b0,
               $sformatf("rnd%0d", r));
    end

    // Reset after four responses, with responses still in flight.
    lat = 4;
    mode = 0;
    for (int i = 0; i < 8; i++) mem[16'h3000 + 16'(i)] = 16'($urandom);
    tick;
    start = 1'b1;
    base_addr = 16'h3000;
    t0 = cyc;
    tick;
    start = 1'b0;
    while (cyc < t0 + 9) tick;
    rst = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst req", {15'd0, req_valid, req_addr}, 32'd0);
    check("rst valid/err", {30'd0, mat_valid, err}, 32'd0);
    check("rst a11", {16'd0, a11}, 32'd0);
    tick;
    rst = 1'b1;
    tick;
    check("late rsp err", {31'd0, err}, 32'd1);
    check("late rsp idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) last_exp[i] = '0;
    repeat (6) tick;

    run_load(tbl[0].base, tbl[0].lat, tbl[0].mode, tbl[0].exp_lat,
             1'b1, 1'b0, "recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Fetches the eight 16-bit operand words of a 2x2 by 2x2 matrix product from word-addressed memory and presents them in parallel to the matrix multiplier: a11, a12, a21, a22, b11, b12, b21, b22. The loader issues sequential reads over a valid/ready request channel and collects in-order responses. It then holds the full operand set stable with a valid/ack handshake. It sits between the memory read port and the multiplier's operand inputs.

## Interface
- ADDR_W, 16, memory word-address width
- DATA_W, 16, operand word width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle request to begin a fetch; sampled only in IDLE
- base_addr  input  ADDR_W  address of a11; latched on accepted start
- req_valid  output  1  read request valid
- req_ready  input  1  memory accepts request this cycle
- req_addr  output  ADDR_W  read address
- rsp_valid  input  1  read data valid; in order, no backpressure
- rsp_data  input  DATA_W  read data
- a11, a12, a21, a22, b11, b12, b21, b22  output  DATA_W each  operand registers
- mat_valid  output  1  full operand set held stable
- mat_ack  input  1  consumer has taken the operands
- busy  output  1  state is not IDLE
- err  output  1  sticky flag for an unexpected response

## Operation
- States: IDLE, FETCH, HOLD. Encoding 2 bits. The unused code goes to IDLE.
- IDLE:
  - start=1 latches base_addr.
  - Clears issued/returned counters (0..8) and err.
  - Next state FETCH.
- FETCH, request side:
  - req_valid=1 while issued<8.
  - req_addr = base + issued, computed modulo 2^ADDR_W.
  - A handshake (req_valid & req_ready) increments issued.
- FETCH, response side:
  - A response with returned<issued writes rsp_data into slot[returned], then increments returned.
  - Slot order is 0..7 = a11, a12, a21, a22, b11, b12, b21, b22.
- FETCH exit: the cycle in which the 8th response is captured moves the state to HOLD.
- HOLD:
  - mat_valid=1; operands are frozen.
  - mat_ack=1 moves the state to IDLE, and mat_valid drops next cycle.
  - Operand registers keep their last values in IDLE.
- Unexpected response: rsp_valid with no outstanding request (in any state, or in FETCH with returned==issued).
  - Sets err. Data is discarded.
  - err stays set until the next accepted start.
- start outside IDLE is ignored. mat_ack outside HOLD is ignored.
- start and mat_ack in the same cycle in HOLD: the ack is taken and the state goes to IDLE. The start is dropped.
- A same-cycle request handshake and response are both processed. The response is checked against issued before that cycle's increment.

## Timing
- Reset values, asynchronous:
  - State IDLE.
  - All counters 0.
  - All operands 0.
  - req_valid, req_addr, mat_valid, busy and err all 0.
- Reset mid-FETCH or mid-HOLD aborts to IDLE.
- Responses still in flight after reset release set err.
- Outputs are registered except req_valid, req_addr and busy, which decode from state and counters.
- Latency with req_ready held at 1 and one-cycle read latency:
  - start in cycle 0.
  - Requests in cycles 1-8.
  - Responses in cycles 2-9.
  - mat_valid=1 in cycle 10.
- Minimum start to mat_valid is 10 cycles. The maximum is unbounded and set by memory stalls.
- Back-to-back loads: the earliest next start is in the cycle after the ack.

## Configuration
- MATLOAD_OUTPUT_MASK_EN defined:
  - All eight operand outputs read 0 whenever mat_valid=0.
  - Internal registers still fill normally.
  - This keeps the multiplier, whose start condition keys on nonzero b22, from firing on a partial load.
- Not defined: the operand outputs drive the internal registers directly at all times.

## Structure
- Shared package matrix_pkg holds:
  - The state enum matload_state_t.
  - NUM_OPERANDS=8.
  - Slot index constants SLOT_A11..SLOT_B22.
  - The default widths.
- One sub-module, matrix_operand_regs:
  - An 8-entry DATA_W register file with write enable and write index.
  - Parallel outputs.
  - The mask gate under MATLOAD_OUTPUT_MASK_EN.
- FSM, counters and handshake logic live in the top.

## Test plan
- Basic load:
  - Stimulus: base_addr=0x0100; memory holds 1..8 at 0x0100..0x0107; req_ready=1; read latency 1.
  - Expected: req_addr runs 0x0100..0x0107; a11=1 ... b22=8; mat_valid rises in cycle 10 after start; mat_ack clears it next cycle.
- Wrap-around:
  - Stimulus: base_addr=0xFFFC.
  - Expected: addresses 0xFFFC..0xFFFF, then 0x0000..0x0003; slots filled in order.
- Backpressure:
  - Stimulus: req_ready toggles 1,0,1,0; latency 3.
  - Expected: exactly 8 handshakes; data in the correct slots; mat_valid only after the 8th response.
- Protocol misuse:
  - Stimulus: start during FETCH, and start with mat_ack in HOLD.
  - Expected: no restart; state goes to IDLE after the ack.
  - Stimulus: a stray rsp_valid in IDLE.
  - Expected: err=1, operands unchanged; err cleared by the next start.
- Reset mid-fetch:
  - Stimulus: assert rst after 4 responses.
  - Expected: all outputs 0 immediately; IDLE; a late response sets err.
- Mask build:
  - Stimulus: MATLOAD_OUTPUT_MASK_EN defined; loader in FETCH with slots 0..6 written.
  - Expected: b22 and all other operands read 0 until mat_valid=1.
